// File: rtl/bilinear_fetch.sv
// Bilinear source fetcher: walks a destination raster, reads the 2x2 source
// neighbourhood per output pixel and presents it with its interpolation weights.
module bilinear_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] src_w,
  input  logic [10:0] src_h,
  input  logic [10:0] dst_w,
  input  logic [10:0] dst_h,
  input  logic [18:0] step_x,
  input  logic [18:0] step_y,
  output logic [19:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic [7:0]  doutbx,
  output logic [7:0]  doutbx1,
  output logic [7:0]  doutby,
  output logic [7:0]  doutby1,
  output logic [9:0]  coefficient1,
  output logic [9:0]  coefficient2,
  output logic [9:0]  coefficient3,
  output logic [9:0]  coefficient4,
  output logic        en_b,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, ROW, FETCH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;

  logic [10:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [18:0] step_x_q, step_y_q, sx_q, sy_q;
  logic [10:0] col_q, row_q;
  logic [19:0] base0_q, base1_q;
  logic [8:0]  fy_q;
  logic        busy_q, rd_vld_q;
  logic [1:0]  rd_ph_q;
  logic [7:0]  p0_q, p1_q, p2_q;
  logic [8:0]  pend_fx_q, pend_fy_q;
  logic        pend_last_q;
  logic [7:0]  b0_q, b1_q, b2_q, b3_q;
  logic [9:0]  c1_q, c2_q, c3_q, c4_q;
  logic        en_b_q, frame_done_q;

  logic        accept, empty, phase3, col_last, row_last;
  logic [10:0] w_m1, h_m1;
  logic        clamp_x, clamp_y;
  logic [9:0]  x0_c, x1_c, y0_c, y1_c;
  logic [8:0]  fx_c, fy_c;

  assign accept   = start && (state_q == IDLE) && !busy_q;
  assign empty    = (dst_w == 11'd0) || (dst_h == 11'd0);
  assign phase3   = (state_q == FETCH) && (phase_q == 2'd3);
  assign col_last = (col_q == dst_w_q - 11'd1);
  assign row_last = (row_q == dst_h_q - 11'd1);

  // Integer part at or beyond the last column/row clamps both taps to the edge with zero fraction.
  assign w_m1    = src_w_q - 11'd1;
  assign h_m1    = src_h_q - 11'd1;
  assign clamp_x = {1'b0, sx_q[18:9]} >= w_m1;
  assign clamp_y = {1'b0, sy_q[18:9]} >= h_m1;
  assign x0_c    = clamp_x ? w_m1[9:0] : sx_q[18:9];
  assign x1_c    = clamp_x ? w_m1[9:0] : sx_q[18:9] + 10'd1;
  assign fx_c    = clamp_x ? 9'd0 : sx_q[8:0];
  assign y0_c    = clamp_y ? h_m1[9:0] : sy_q[18:9];
  assign y1_c    = clamp_y ? h_m1[9:0] : sy_q[18:9] + 10'd1;
  assign fy_c    = clamp_y ? 9'd0 : sy_q[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE:  if (accept && !empty) state_d = ROW;
      ROW: begin
        state_d = FETCH;
        phase_d = 2'd0;
      end
      FETCH: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3 && col_last) state_d = row_last ? IDLE : ROW;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en = (state_q == FETCH);

  always_comb begin
    rd_addr = 20'd0;
    if (state_q == FETCH) begin
      case (phase_q)
        2'd0:    rd_addr = base0_q + 20'(x0_c);
        2'd1:    rd_addr = base0_q + 20'(x1_c);
        2'd2:    rd_addr = base1_q + 20'(x0_c);
        default: rd_addr = base1_q + 20'(x1_c);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_w_q <= '0; src_h_q <= '0; dst_w_q <= '0; dst_h_q <= '0;
      step_x_q <= '0; step_y_q <= '0; sx_q <= '0; sy_q <= '0;
      col_q <= '0; row_q <= '0; base0_q <= '0; base1_q <= '0; fy_q <= '0;
      busy_q <= 1'b0; rd_vld_q <= 1'b0; rd_ph_q <= '0;
      p0_q <= '0; p1_q <= '0; p2_q <= '0;
      pend_fx_q <= '0; pend_fy_q <= '0; pend_last_q <= 1'b0;
      b0_q <= '0; b1_q <= '0; b2_q <= '0; b3_q <= '0;
      c1_q <= '0; c2_q <= '0; c3_q <= '0; c4_q <= '0;
      en_b_q <= 1'b0; frame_done_q <= 1'b0;
    end else begin
      en_b_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_vld_q     <= rd_en;
      rd_ph_q      <= phase_q;
      // An empty frame keeps busy for exactly the one cycle after start.
      if (state_q == IDLE) busy_q <= 1'b0;
      if (accept) begin
        src_w_q  <= src_w;  src_h_q  <= src_h;
        dst_w_q  <= dst_w;  dst_h_q  <= dst_h;
        step_x_q <= step_x; step_y_q <= step_y;
        sx_q <= '0; sy_q <= '0; col_q <= '0; row_q <= '0;
        busy_q       <= 1'b1;
        frame_done_q <= empty;
      end
      if (state_q == ROW) begin
        base0_q <= 20'(y0_c) * 20'(src_w_q);
        base1_q <= 20'(y1_c) * 20'(src_w_q);
        fy_q    <= fy_c;
      end
      if (phase3) begin
        pend_fx_q   <= fx_c;
        pend_fy_q   <= fy_q;
        pend_last_q <= col_last && row_last;
        if (!col_last) begin
          col_q <= col_q + 11'd1;
          sx_q  <= sx_q + step_x_q;
        end else if (!row_last) begin
          row_q <= row_q + 11'd1;
          sy_q  <= sy_q + step_y_q;
          sx_q  <= '0;
          col_q <= '0;
        end else begin
          busy_q <= 1'b0;
        end
      end
      // Read data trails its address by one cycle; the fourth tap completes the set.
      if (rd_vld_q) begin
        case (rd_ph_q)
          2'd0: p0_q <= rd_data;
          2'd1: p1_q <= rd_data;
          2'd2: p2_q <= rd_data;
          default: begin
            b0_q <= p0_q; b1_q <= p1_q; b2_q <= p2_q; b3_q <= rd_data;
            c1_q <= 10'd512 - {1'b0, pend_fx_q};
            c2_q <= {1'b0, pend_fx_q};
            c3_q <= 10'd512 - {1'b0, pend_fy_q};
            c4_q <= {1'b0, pend_fy_q};
            en_b_q       <= 1'b1;
            frame_done_q <= pend_last_q;
          end
        endcase
      end
    end
  end

  assign doutbx       = b0_q;
  assign doutbx1      = b1_q;
  assign doutby       = b2_q;
  assign doutby1      = b3_q;
  assign coefficient1 = c1_q;
  assign coefficient2 = c2_q;
  assign coefficient3 = c3_q;
  assign coefficient4 = c4_q;
  assign en_b         = en_b_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_bilinear_fetch.sv
// Scoreboard bench for bilinear_fetch: a frame-level model queues expected
// neighbourhoods at start; a negedge monitor pops and compares on each en_b.
module tb_bilinear_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [10:0] src_w, src_h, dst_w, dst_h;
  logic [18:0] step_x, step_y;
  logic [19:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [7:0]  doutbx, doutbx1, doutby, doutby1;
  logic [9:0]  coefficient1, coefficient2, coefficient3, coefficient4;
  logic        en_b, busy, frame_done;

  bilinear_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .step_x(step_x), .step_y(step_y),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .doutbx(doutbx), .doutbx1(doutbx1), .doutby(doutby), .doutby1(doutby1),
    .coefficient1(coefficient1), .coefficient2(coefficient2),
    .coefficient3(coefficient3), .coefficient4(coefficient4),
    .en_b(en_b), .busy(busy), .frame_done(frame_done)
  );

  logic [7:0] mem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[9:0]];

  typedef struct {
    logic [31:0] pix;
    logic [39:0] coef;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_enb = 0, n_rd = 0, n_done = 0, exp_empty = 0;
  int   cur_area = 4;
  int   rd_log[$], rd_cyc[$], enb_cyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Clamped integer/fraction split of one 10.9 coordinate.
  function automatic void axis(input int v, input int size, output int p0, output int p1, output int f);
    int iv;
    iv = v / 512;
    if (iv >= size - 1) begin
      p0 = size - 1; p1 = size - 1; f = 0;
    end else begin
      p0 = iv; p1 = iv + 1; f = v % 512;
    end
  endfunction

  task automatic push_frame(input int sw, input int sh, input int dw, input int dh,
                            input int stx, input int sty);
    exp_t e;
    int x0, x1, fx, y0, y1, fy;
    if (dw == 0 || dh == 0) begin
      exp_empty++;
      return;
    end
    for (int r = 0; r < dh; r++) begin
      for (int c = 0; c < dw; c++) begin
        axis(r * sty, sh, y0, y1, fy);
        axis(c * stx, sw, x0, x1, fx);
        e.pix  = {mem[y0*sw+x0], mem[y0*sw+x1], mem[y1*sw+x0], mem[y1*sw+x1]};
        e.coef = {10'(512 - fx), 10'(fx), 10'(512 - fy), 10'(fy)};
        e.last = (r == dh - 1) && (c == dw - 1);
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (rd_en) begin
        n_rd++;
        rd_log.push_back(int'(rd_addr));
        rd_cyc.push_back(cyc);
        chk("rd_addr_in_frame", (int'(rd_addr) < cur_area), 1);
      end
      if (frame_done) n_done++;
      if (en_b) begin
        n_enb++;
        enb_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_en_b", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pixels", {doutbx, doutbx1, doutby, doutby1}, e.pix);
          chk("coefficients", {coefficient1, coefficient2, coefficient3, coefficient4}, e.coef);
          chk("frame_done_with_last", frame_done, e.last);
        end
      end else if (frame_done) begin
        chk("empty_frame_done_expected", (exp_empty > 0), 1);
        if (exp_empty > 0) exp_empty--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int sw, input int sh, input int dw, input int dh,
                           input int stx, input int sty, input bit accepted);
    src_w = 11'(sw); src_h = 11'(sh); dst_w = 11'(dw); dst_h = 11'(dh);
    step_x = 19'(stx); step_y = 19'(sty);
    start = 1'b1;
    if (accepted) begin
      cur_area = sw * sh;
      push_frame(sw, sh, dw, dh, stx, sty);
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((busy || sb.size() != 0 || exp_empty != 0) && k < budget) begin
      step();
      k++;
    end
    chk(name, (k < budget), 1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {rd_en, en_b, busy, frame_done}, 0);
    chk({name, "_pix"}, {doutbx, doutbx1, doutby, doutby1}, 0);
    chk({name, "_coef"}, {coefficient1, coefficient2, coefficient3, coefficient4}, 0);
    chk({name, "_addr"}, rd_addr, 0);
  endtask

  initial begin
    int e0, d0, r0, k, bad, sw, sh, dw, dh;
    rst = 1'b1; start = 1'b0; rd_data = 8'd0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; step_x = '0; step_y = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // 2x2 -> 1x1: four consecutive reads, single en_b with frame_done.
    rd_log.delete(); rd_cyc.delete(); e0 = n_enb; d0 = n_done;
    run_start(2, 2, 1, 1, 512, 512, 1'b1);
    wait_idle(200, "d1_complete");
    chk("d1_reads", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("d1_rd_addr", rd_log[i], i);
    if (rd_cyc.size() == 4) chk("d1_rd_consecutive", rd_cyc[3] - rd_cyc[0], 3);
    chk("d1_en_b_count", n_enb - e0, 1);
    chk("d1_frame_done_count", n_done - d0, 1);

    // 2x2 -> 4x4 upscale with clamping columns/rows.
    rd_log.delete(); enb_cyc.delete(); e0 = n_enb;
    run_start(2, 2, 4, 4, 256, 256, 1'b1);
    wait_idle(400, "d2_complete");
    chk("d2_en_b_count", n_enb - e0, 16);
    if (enb_cyc.size() >= 4) begin
      chk("d2_en_b_spacing01", enb_cyc[1] - enb_cyc[0], 4);
      chk("d2_en_b_spacing23", enb_cyc[3] - enb_cyc[2], 4);
    end
    if (rd_log.size() == 64) begin
      chk("d2_col2_x0", rd_log[8], 1);
      chk("d2_col2_x1", rd_log[9], 1);
      bad = 0;
      for (int i = 32; i < 48; i++) if (rd_log[i] < 2 || rd_log[i] > 3) bad++;
      chk("d2_row2_addr_range", bad, 0);
    end

    // Reset in phase 2 of pixel 5.
    run_start(2, 2, 4, 4, 256, 256, 1'b1);
    k = 0;
    for (int g = 0; g < 500 && k < 23; g++) begin
      step();
      if (rd_en) k++;
    end
    chk("d3_reach_pix5_ph2", k, 23);
    rst = 1'b1;
    step();
    check_zero("d3_abort");
    rst = 1'b0;
    sb.delete();
    e0 = n_enb; d0 = n_done;
    repeat (30) step();
    chk("d3_no_en_b_after_rst", n_enb - e0, 0);
    chk("d3_no_done_after_rst", n_done - d0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_start(2, 2, 4, 4, 256, 256, 1'b1);
    wait_idle(400, "d3_restart_complete");
    chk("d3_restart_en_b", n_enb - e0, 16);

    // Start while busy ignored; empty frame.
    e0 = n_enb;
    run_start(2, 2, 4, 4, 256, 256, 1'b1);
    repeat (5) step();
    run_start(2, 2, 2, 2, 512, 512, 1'b0);
    wait_idle(400, "d4_complete");
    chk("d4_ignored_start_en_b", n_enb - e0, 16);
    r0 = n_rd; d0 = n_done;
    run_start(2, 2, 0, 3, 512, 512, 1'b1);
    chk("d4_empty_done_next", {busy, frame_done}, 2'b11);
    step();
    chk("d4_empty_after", {busy, frame_done}, 2'b00);
    wait_idle(20, "d4_empty_complete");
    chk("d4_empty_no_reads", n_rd - r0, 0);
    chk("d4_empty_done_count", n_done - d0, 1);

    // Back-to-back frames.
    e0 = n_enb; d0 = n_done;
    run_start(2, 2, 3, 2, 300, 400, 1'b1);
    k = 0;
    while (!frame_done && k < 400) begin
      step();
      k++;
    end
    chk("d5_first_done_seen", frame_done, 1);
    step();
    run_start(2, 2, 2, 3, 200, 350, 1'b1);
    wait_idle(400, "d5_complete");
    chk("d5_en_b_total", n_enb - e0, 12);
    chk("d5_done_total", n_done - d0, 2);

    // Randomized frames.
    for (int t = 0; t < 25; t++) begin
      sw = $urandom_range(2, 8); sh = $urandom_range(2, 8);
      dw = $urandom_range(0, 6); dh = $urandom_range(0, 6);
      for (int i = 0; i < sw * sh; i++) mem[i] = 8'($urandom);
      r0 = n_rd; e0 = n_enb;
      run_start(sw, sh, dw, dh,
                $urandom_range(0, (sw * 640) / (dw > 0 ? dw : 1)),
                $urandom_range(0, (sh * 640) / (dh > 0 ? dh : 1)), 1'b1);
      wait_idle(2000, "rand_complete");
      chk("rand_reads", n_rd - r0, 4 * dw * dh);
      chk("rand_en_b", n_enb - e0, dw * dh);
    end

    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bilinear_fetch.md
BILINEAR_FETCH -- requirements
Module: bilinear_fetch

Interface
REQ-001 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- src_w, src_h  in  11 each  source dimensions, 2..1024.
- dst_w, dst_h  in  11 each  destination dimensions, 0..1024.
- step_x, step_y  in  19 each  source step per destination pixel, unsigned 10.9 fixed point.
- rd_addr  out  20  source frame memory read address, row-major y*src_w+x.
- rd_en  out  1  read strobe.
- rd_data  in  8  pixel data returned by the memory.
- doutbx, doutbx1, doutby, doutby1  out  8 each  pixels (x0,y0), (x1,y0), (x0,y1), (x1,y1).
- coefficient1..coefficient4  out  10 each  weights 512-fx, fx, 512-fy, fy.
- en_b  out  1  neighbourhood/coefficients valid.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-002 rd_data SHALL be valid in the cycle after rd_en/rd_addr are presented.
REQ-003 In IDLE, start SHALL latch all dimension and step inputs, clear sx, sy, col and row to 0, and set busy.
REQ-004 start while busy SHALL be ignored.
REQ-005 States SHALL be IDLE, ROW and FETCH; FETCH has phases 0..3.
REQ-006 ROW SHALL last 1 cycle and SHALL compute y0 = min(sy[18:9], src_h-1) and y1 = min(y0+1, src_h-1).
REQ-007 If sy[18:9] >= src_h-1, fy SHALL be 0; otherwise fy = sy[8:0].
REQ-008 ROW SHALL compute base0 = y0*src_w and base1 = y1*src_w.
REQ-009 x0, x1 and fx SHALL follow the REQ-006/REQ-007 rules using sx and src_w.
REQ-010 In FETCH, rd_en SHALL be high, with rd_addr in phases 0..3 equal to base0+x0, base0+x1, base1+x0 and base1+x1.
REQ-011 Data returned for phases 0..2 SHALL be captured internally.
REQ-012 Data for phase 3 SHALL be captured the following cycle, together with the outputs below.
REQ-013 In the capture cycle, all four pixel outputs and the four coefficients SHALL load simultaneously, and en_b SHALL be high for exactly the next cycle.
REQ-014 The pixel and coefficient outputs SHALL hold until the next load.
REQ-015 After phase 3, if col < dst_w-1: col+1, sx += step_x, then phase 0 in the next cycle, giving one en_b every 4 cycles.
REQ-016 After phase 3 of the last column, if row < dst_h-1: row+1, sy += step_y, sx = 0, col = 0, then ROW.
REQ-017 After phase 3 of the last pixel of the frame: go to IDLE, drop busy, and pulse frame_done in the same cycle as the final en_b.
REQ-018 If dst_w = 0 or dst_h = 0: no reads, no en_b, frame_done one cycle after start, busy high for that one cycle.
REQ-019 rd_en SHALL be low outside FETCH.
REQ-020 coefficient1+coefficient2 = 512 and coefficient3+coefficient4 = 512 SHALL hold at every en_b.

Reset
REQ-021 rst SHALL force IDLE and drive every output and internal register to 0.
REQ-022 rst mid-frame SHALL abort the frame: no further en_b, no frame_done, and a new start is accepted the cycle after rst falls.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- 2x2 source {10,20;30,40}, dst 1x1, steps 512 -> rd_addr 0,1,2,3 on consecutive cycles; one en_b with 10,20,30,40 and coefficients 512,0,512,0; frame_done with it.
- Same source, dst 4x4, steps 256 -> 16 en_b pulses, 4 cycles apart within a row; pixel (1,0) has coefficients 256,256,512,0; columns 2-3 clamp to x0=x1=1 with coefficients 512,0.
- 4x4 dst row 2 (sy=512) -> y0=y1=1; rd_addr only in 2..3; coefficients 3,4 = 512,0.
- rst asserted in phase 2 of pixel 5 -> all outputs 0 the next cycle; no en_b or frame_done afterwards; a following start runs a full frame.
- start pulsed while busy -> ignored, en_b count unchanged; start with dst_w=0 -> frame_done 1 cycle later, rd_en never high.
- Back-to-back frames, second start the cycle after frame_done -> both frames complete with correct en_b counts.
